// File: rtl/mv_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states, accumulator ops.
package mv_pkg;

  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_STOP  = 3'b000;
  localparam logic [OPW-1:0] OP_ADD   = 3'b001;
  localparam logic [OPW-1:0] OP_SUB   = 3'b010;
  localparam logic [OPW-1:0] OP_LOAD  = 3'b011;
  localparam logic [OPW-1:0] OP_STORE = 3'b100;
  localparam logic [OPW-1:0] OP_JUMP  = 3'b101;
  localparam logic [OPW-1:0] OP_JZ    = 3'b110;
  localparam logic [OPW-1:0] OP_NOP   = 3'b111;

  typedef enum logic [3:0] {
    IDLE, F0, F1, F2, DEC, E0, E1, E2, EJ, HALT
  } state_t;

  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_LOAD = 2'b01;
  localparam logic [1:0] ACC_ADD  = 2'b10;
  localparam logic [1:0] ACC_SUB  = 2'b11;

  function automatic logic [1:0] acc_code(input logic [OPW-1:0] op);
    unique case (op)
      OP_LOAD: return ACC_LOAD;
      OP_ADD:  return ACC_ADD;
      OP_SUB:  return ACC_SUB;
      default: return ACC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cs_decode.sv
// Moore output decode: strobes depend only on the current state and the IR opcode.
module cs_decode import mv_pkg::*; (
  input  state_t         state,
  input  logic [OPW-1:0] opcode,
  output logic           read,
  output logic           write,
  output logic           Ain,
  output logic           Din,
  output logic           Dout,
  output logic [1:0]     acc_op,
  output logic           acc_out,
  output logic           halted
);

  logic is_store;
  assign is_store = (opcode == OP_STORE);

  always_comb begin
    read    = 1'b0;
    write   = 1'b0;
    Ain     = 1'b0;
    Din     = 1'b0;
    Dout    = 1'b0;
    acc_op  = ACC_NONE;
    acc_out = 1'b0;
    halted  = 1'b0;
    unique case (state)
      F0: Ain = 1'b1;
      F1: read = 1'b1;
      F2: Dout = 1'b1;
      E0: begin
        Ain = 1'b1;
        // STORE latches the accumulator into Memory's data register alongside the address.
        Din     = is_store;
        acc_out = is_store;
      end
      E1: begin
        write   = is_store;
        acc_out = is_store;
        read    = !is_store;
      end
      E2: begin
        Dout   = 1'b1;
        acc_op = acc_code(opcode);
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute sequencer: owns PC, IR and the state register; output strobes come from cs_decode.
module control_sequencer import mv_pkg::*; #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          acc_zero,
  input  logic [DW-1:0] Dbus,
  output logic [AW-1:0] Abus,
  output logic          read,
  output logic          write,
  output logic          Ain,
  output logic          Din,
  output logic          Dout,
  output logic [1:0]    acc_op,
  output logic          acc_out,
  output logic          halted,
  output logic [AW-1:0] pc
);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;

  logic [DW-AW-1:0] opcode;
  logic [AW-1:0]    addr;

  assign opcode = ir_q[DW-1:AW];
  assign addr   = ir_q[AW-1:0];
  assign pc     = pc_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      IDLE, HALT: if (start) state_d = F0;
      F0: state_d = F1;
      F1: state_d = F2;
      F2: begin
        ir_d    = Dbus;
        pc_d    = pc_q + AW'(1);
        state_d = DEC;
      end
      DEC: begin
        unique case (opcode)
          OP_STOP:                            state_d = HALT;
          OP_LOAD, OP_ADD, OP_SUB, OP_STORE: state_d = E0;
          OP_JUMP, OP_JZ:                     state_d = EJ;
          OP_NOP:                             state_d = F0;
          default:                            state_d = F0;
        endcase
      end
      E0: state_d = E1;
      E1: state_d = (opcode == OP_STORE) ? F0 : E2;
      E2: state_d = F0;
      EJ: begin
        // Only JUMP and JZ reach EJ, so anything that is not JUMP is a conditional branch.
        if ((opcode == OP_JUMP) || acc_zero) pc_d = addr;
        state_d = F0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Abus = '0;
    unique case (state_q)
      F0, F1, F2: Abus = pc_q;
      E0, E1, E2: Abus = addr;
      default:    Abus = '0;
    endcase
  end

  cs_decode u_decode (
    .state   (state_q),
    .opcode  (opcode),
    .read    (read),
    .write   (write),
    .Ain     (Ain),
    .Din     (Din),
    .Dout    (Dout),
    .acc_op  (acc_op),
    .acc_out (acc_out),
    .halted  (halted)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench: Memory + accumulator around control_sequencer, ISA-level model with per-cycle compare.
module tb_control_sequencer;

  logic       CLK;
  logic       RST;
  logic       start;
  logic       acc_zero;
  logic [7:0] Dbus;
  logic [4:0] Abus;
  logic       read, write, Ain, Din, Dout, acc_out, halted;
  logic [1:0] acc_op;
  logic [4:0] pc;

  control_sequencer #(.AW(5), .DW(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .acc_zero (acc_zero),
    .Dbus     (Dbus),
    .Abus     (Abus),
    .read     (read),
    .write    (write),
    .Ain      (Ain),
    .Din      (Din),
    .Dout     (Dout),
    .acc_op   (acc_op),
    .acc_out  (acc_out),
    .halted   (halted),
    .pc       (pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory and accumulator
  logic [7:0] mem [32];
  logic [7:0] img [32];
  logic       ld_en;
  logic [4:0] mar;
  logic [7:0] mdr;
  logic [7:0] acc;

  assign Dbus     = Dout ? mdr : (acc_out ? acc : 8'h00);
  assign acc_zero = (acc == 8'h00);

  always @(posedge CLK) begin
    if (ld_en) begin
      for (int i = 0; i < 32; i++) mem[i] <= img[i];
    end else begin
      if (Ain)   mar <= Abus;
      if (Din)   mdr <= Dbus;
      if (read)  mdr <= mem[mar];
      if (write) mem[mar] <= mdr;
    end
  end

  always @(posedge CLK or posedge RST) begin
    if (RST) acc <= 8'h00;
    else begin
      case (acc_op)
        2'b01:   acc <= Dbus;
        2'b10:   acc <= acc + Dbus;
        2'b11:   acc <= acc - Dbus;
        default: ;
      endcase
    end
  end

  // Model: instruction-level execution producing the expected per-cycle output trace
  logic [7:0]  m_mem [32];
  logic [4:0]  m_pc;
  logic [7:0]  m_acc;
  logic [18:0] exp_q[$];

  logic [18:0] act_vec;
  assign act_vec = {Abus, read, write, Ain, Din, Dout, acc_op, acc_out, halted, pc};

  // strb = {read, write, Ain, Din, Dout}
  function automatic logic [18:0] mk(input logic [4:0] ab, input logic [4:0] strb,
                                     input logic [1:0] aop, input logic ao, input logic hl,
                                     input logic [4:0] p);
    return {ab, strb, aop, ao, hl, p};
  endfunction

  task automatic model_run(input logic from_halt);
    logic [7:0] ins;
    logic [2:0] op;
    logic [4:0] a;
    logic [1:0] aop;
    bit         done;
    int         guard;
    exp_q.push_back(mk(5'd0, 5'b00000, 2'b00, 1'b0, from_halt, m_pc));
    done  = 0;
    guard = 0;
    while (!done && guard < 200) begin
      guard++;
      ins = m_mem[m_pc];
      op  = ins[7:5];
      a   = ins[4:0];
      exp_q.push_back(mk(m_pc, 5'b00100, 2'b00, 1'b0, 1'b0, m_pc));
      exp_q.push_back(mk(m_pc, 5'b10000, 2'b00, 1'b0, 1'b0, m_pc));
      exp_q.push_back(mk(m_pc, 5'b00001, 2'b00, 1'b0, 1'b0, m_pc));
      m_pc = m_pc + 5'd1;
      exp_q.push_back(mk(5'd0, 5'b00000, 2'b00, 1'b0, 1'b0, m_pc));
      case (op)
        3'b001, 3'b010, 3'b011: begin
          aop = (op == 3'b011) ? 2'b01 : ((op == 3'b001) ? 2'b10 : 2'b11);
          exp_q.push_back(mk(a, 5'b00100, 2'b00, 1'b0, 1'b0, m_pc));
          exp_q.push_back(mk(a, 5'b10000, 2'b00, 1'b0, 1'b0, m_pc));
          exp_q.push_back(mk(a, 5'b00001, aop, 1'b0, 1'b0, m_pc));
          if (op == 3'b011)      m_acc = m_mem[a];
          else if (op == 3'b001) m_acc = m_acc + m_mem[a];
          else                   m_acc = m_acc - m_mem[a];
        end
        3'b100: begin
          exp_q.push_back(mk(a, 5'b00110, 2'b00, 1'b1, 1'b0, m_pc));
          exp_q.push_back(mk(a, 5'b01000, 2'b00, 1'b1, 1'b0, m_pc));
          m_mem[a] = m_acc;
        end
        3'b101: begin
          exp_q.push_back(mk(5'd0, 5'b00000, 2'b00, 1'b0, 1'b0, m_pc));
          m_pc = a;
        end
        3'b110: begin
          exp_q.push_back(mk(5'd0, 5'b00000, 2'b00, 1'b0, 1'b0, m_pc));
          if (m_acc == 8'h00) m_pc = a;
        end
        3'b000: begin
          exp_q.push_back(mk(5'd0, 5'b00000, 2'b00, 1'b0, 1'b1, m_pc));
          done = 1;
        end
        default: ;
      endcase
    end
  endtask

  // Per-cycle compare against the model trace
  always @(negedge CLK) begin
    logic [18:0] e;
    if (!RST && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle", {13'd0, act_vec}, {13'd0, e});
    end
  end

  // Protocol checker, active throughout
  logic prev_ain = 1'b0;
  always @(negedge CLK) begin
    if (RST) prev_ain = 1'b0;
    else begin
      check("rd_wr_excl", {31'd0, read & write}, 32'd0);
      check("dout_accout_excl", {31'd0, Dout & acc_out}, 32'd0);
      check("ain_then_access", {31'd0, read | write}, {31'd0, prev_ain});
      prev_ain = Ain;
    end
  end

  logic [4:0] ain_log[$];
  logic [2:0] aop_log[$];
  always @(negedge CLK) begin
    if (!RST) begin
      if (Ain) ain_log.push_back(Abus);
      if (acc_op != 2'b00) aop_log.push_back({Dout, acc_op});
    end
  end

  task automatic clear_img();
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
  endtask

  task automatic restart();
    RST   = 1'b1;
    start = 1'b0;
    m_pc  = 5'd0;
    m_acc = 8'h00;
    for (int i = 0; i < 32; i++) m_mem[i] = img[i];
    ld_en = 1'b1;
    @(posedge CLK); #1;
    ld_en = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    ain_log.delete();
    aop_log.delete();
  endtask

  task automatic pulse_start(input int len);
    start = 1'b1;
    repeat (len) @(posedge CLK);
    #1 start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    check("trace_drained", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  logic [4:0] exp_ain [11] = '{5'd0, 5'd16, 5'd1, 5'd0, 5'd2, 5'd5, 5'd17, 5'd6, 5'd7,
                               5'd31, 5'd0};
  int n;

  initial begin
    RST   = 1'b1;
    start = 1'b0;
    ld_en = 1'b0;
    clear_img();

    // 1. Reset mid-F1, then idle with start low
    img[0] = 8'h70; img[1] = 8'h91; img[2] = 8'h00; img[16] = 8'hA5;
    restart();
    check("t1_idle_outputs", {13'd0, act_vec}, 32'd0);
    pulse_start(1);
    @(posedge CLK); #2;
    check("t1_in_f1_read", {31'd0, read}, 32'd1);
    RST = 1'b1;
    #1;
    check("t1_reset_outputs", {13'd0, act_vec}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("t1_stays_idle", {13'd0, act_vec}, 32'd0);

    // 2. LOAD 16 / STORE 17 / STOP
    restart();
    model_run(1'b0);
    check("t2_model_len", exp_q.size(), 32'd19);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    n = 0;
    while (!halted && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    check("t2_cycles_to_halt", n, 32'd17);
    wait_drain();
    check("t2_mem17", {24'd0, mem[17]}, 32'h000000A5);
    check("t2_pc", {27'd0, pc}, 32'd3);
    check("t2_halted", {31'd0, halted}, 32'd1);

    // 3. Arithmetic, start held high while executing
    clear_img();
    img[0] = 8'h70; img[1] = 8'h31; img[2] = 8'h52; img[3] = 8'h93; img[4] = 8'h00;
    img[16] = 8'h05; img[17] = 8'h03; img[18] = 8'h01;
    restart();
    model_run(1'b0);
    pulse_start(3);
    wait_drain();
    check("t3_mem19", {24'd0, mem[19]}, 32'h00000007);
    check("t3_accop_count", aop_log.size(), 32'd3);
    if (aop_log.size() == 3) begin
      check("t3_accop_load", {29'd0, aop_log[0]}, 32'd5);
      check("t3_accop_add",  {29'd0, aop_log[1]}, 32'd6);
      check("t3_accop_sub",  {29'd0, aop_log[2]}, 32'd7);
    end

    // 4. Branching: JZ taken, JZ not taken, JUMP 31 + NOP wrap into self-modified STOP
    clear_img();
    img[0] = 8'h70; img[1] = 8'h80; img[2] = 8'hC5;
    img[5] = 8'h71; img[6] = 8'hC9; img[7] = 8'hBF; img[8] = 8'h00;
    img[16] = 8'h00; img[17] = 8'h01; img[31] = 8'hE0;
    restart();
    model_run(1'b0);
    pulse_start(1);
    wait_drain();
    check("t4_ain_count", ain_log.size(), 32'd11);
    for (int i = 0; i < 11; i++) begin
      if (i < ain_log.size()) check("t4_ain_addr", {27'd0, ain_log[i]}, {27'd0, exp_ain[i]});
    end
    check("t4_pc_after_wrap", {27'd0, pc}, 32'd1);
    check("t4_halted", {31'd0, halted}, 32'd1);

    // Resume from HALT: STORE 0 (acc=1), JZ 5 not taken, STOP at 3
    model_run(1'b1);
    pulse_start(1);
    wait_drain();
    check("t4_resume_pc", {27'd0, pc}, 32'd4);
    check("t4_resume_mem0", {24'd0, mem[0]}, 32'h00000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
